// File: rtl/fifo_flex_if.sv
// Handshake bundle for fifo_flex: producer/consumer requests, read data and status.
// Error-flag signals exist only when FIFO_ERR_FLAGS_EN is defined.
interface fifo_flex_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 2
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic                  flush;
  logic                  write;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  read;
  logic [DATA_WIDTH-1:0] read_data;
  logic [CntW-1:0]       fill_level;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic                  err_clr;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, write, write_data, read, err_clr,
    input  read_data, fill_level, full, empty, almost_full, almost_empty, overflow, underflow
  );
  modport slave (
    input  flush, write, write_data, read, err_clr,
    output read_data, fill_level, full, empty, almost_full, almost_empty, overflow, underflow
  );
`else
  modport master (
    output flush, write, write_data, read,
    input  read_data, fill_level, full, empty, almost_full, almost_empty
  );
  modport slave (
    input  flush, write, write_data, read,
    output read_data, fill_level, full, empty, almost_full, almost_empty
  );
`endif
endinterface

// File: rtl/fifo_flex.sv
// Synchronous FIFO with any depth, registered or first-word-fall-through read, and status flags.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags with err_clr.
module fifo_flex #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 1,
  parameter int unsigned AE_THRESH  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  fifo_flex_if.slave bus
);
  localparam int unsigned      PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned      CntW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [PtrW-1:0]  LastPtr = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0]  FullCnt = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0]  AfCnt   = CntW'(AF_THRESH);
  localparam logic [CntW-1:0]  AeCnt   = CntW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  full, empty, rd_acc, wr_acc;

  // Explicit wrap so non-power-of-two depths never index past the last slot.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign full   = (count_q == FullCnt);
  assign empty  = (count_q == '0);
  assign rd_acc = bus.read & ~empty & ~bus.flush;
  assign wr_acc = bus.write & (~full | rd_acc) & ~bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (wr_acc && !rd_acc) begin
        count_d = count_q + CntW'(1);
      end else if (!wr_acc && rd_acc) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.write_data;
  end

  assign bus.fill_level   = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AfCnt);
  assign bus.almost_empty = (count_q <= AeCnt);

  if (FWFT != 0) begin : g_fwft
    // Head entry shown combinationally; zero while empty keeps reset output at 0.
    assign bus.read_data = empty ? '0 : mem[rd_ptr_q];
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rdata_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else if (rd_acc) begin
        rdata_q <= mem[rd_ptr_q];
      end
    end
    assign bus.read_data = rdata_q;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;

  // Clear first so a same-cycle error event overrides err_clr.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.write && full && !rd_acc) overflow_d = 1'b1;
    if (bus.read && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex (depth 3, AF=2, AE=1): registered-read instance driven from a
// vector table plus hand sequences, and a first-word-fall-through instance.
module tb_fifo_flex;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fifo_flex_if #(.DATA_WIDTH(8), .FIFO_DEPTH(3)) bus0 ();
  fifo_flex_if #(.DATA_WIDTH(8), .FIFO_DEPTH(3)) bus1 ();

  fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(3), .FWFT(0), .AF_THRESH(2), .AE_THRESH(1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(3), .FWFT(1), .AF_THRESH(2), .AE_THRESH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  typedef struct {
    logic       flush;
    logic       write;
    logic [7:0] wdata;
    logic       read;
    logic [1:0] lvl;
    logic [3:0] flags;  // {full, empty, almost_full, almost_empty}
    logic       chk;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic f, input logic w, input logic [7:0] d, input logic r,
                              input logic [1:0] l, input logic [3:0] fl, input logic c,
                              input logic [7:0] rd);
    vec_t v;
    v.flush = f; v.write = w; v.wdata = d; v.read = r;
    v.lvl = l; v.flags = fl; v.chk = c; v.rdata = rd;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic f, input logic w, input logic [7:0] d, input logic r);
    bus0.flush = f; bus0.write = w; bus0.write_data = d; bus0.read = r;
  endtask

  task automatic drive1(input logic w, input logic [7:0] d, input logic r);
    bus1.write = w; bus1.write_data = d; bus1.read = r;
  endtask

  function automatic logic [3:0] flags0();
    return {bus0.full, bus0.empty, bus0.almost_full, bus0.almost_empty};
  endfunction

  initial begin
    drive0(0, 0, 8'h00, 0);
    bus1.flush = 1'b0;
    drive1(0, 8'h00, 0);
`ifdef FIFO_ERR_FLAGS_EN
    bus0.err_clr = 1'b0;
    bus1.err_clr = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    check("reset level", 32'(bus0.fill_level), 0);
    check("reset flags", 32'(flags0()), 32'b0101);
    check("reset rdata", 32'(bus0.read_data), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // flush write wdata read | level flags chk rdata
    add(0, 1, 8'h11, 0, 1, 4'b0001, 0, 8'h00);
    add(0, 1, 8'h22, 0, 2, 4'b0010, 0, 8'h00);
    add(0, 1, 8'h33, 0, 3, 4'b1010, 1, 8'h00);
    add(0, 0, 8'h00, 1, 2, 4'b0010, 1, 8'h11);
    add(0, 0, 8'h00, 1, 1, 4'b0001, 1, 8'h22);
    add(0, 0, 8'h00, 1, 0, 4'b0101, 1, 8'h33);
    add(0, 1, 8'h55, 0, 1, 4'b0001, 0, 8'h00);
    add(0, 1, 8'h66, 0, 2, 4'b0010, 0, 8'h00);
    add(0, 1, 8'h77, 0, 3, 4'b1010, 0, 8'h00);
    add(0, 1, 8'h44, 1, 3, 4'b1010, 1, 8'h55);  // full: simultaneous read+write
    add(0, 0, 8'h00, 1, 2, 4'b0010, 1, 8'h66);
    add(0, 0, 8'h00, 1, 1, 4'b0001, 1, 8'h77);
    add(0, 0, 8'h00, 1, 0, 4'b0101, 1, 8'h44);
    add(0, 1, 8'h99, 1, 1, 4'b0001, 1, 8'h44);  // read on empty ignored, write taken
    add(0, 0, 8'h00, 1, 0, 4'b0101, 1, 8'h99);
    add(0, 1, 8'h12, 0, 1, 4'b0001, 0, 8'h00);
    add(0, 1, 8'h34, 0, 2, 4'b0010, 0, 8'h00);
    add(1, 1, 8'h56, 0, 0, 4'b0101, 1, 8'h99);  // flush drops write, keeps read_data
    add(0, 1, 8'h78, 0, 1, 4'b0001, 1, 8'h99);
    add(0, 0, 8'h00, 1, 0, 4'b0101, 1, 8'h78);
    add(0, 1, 8'hA1, 0, 1, 4'b0001, 0, 8'h00);
    add(0, 1, 8'hA2, 0, 2, 4'b0010, 0, 8'h00);
    add(0, 1, 8'hA3, 0, 3, 4'b1010, 0, 8'h00);
    add(0, 1, 8'hB4, 0, 3, 4'b1010, 1, 8'h78);  // write when full dropped
    add(0, 0, 8'h00, 1, 2, 4'b0010, 1, 8'hA1);
    add(0, 0, 8'h00, 1, 1, 4'b0001, 1, 8'hA2);
    add(0, 0, 8'h00, 1, 0, 4'b0101, 1, 8'hA3);
    add(0, 1, 8'hC1, 0, 1, 4'b0001, 0, 8'h00);
    add(1, 0, 8'h00, 1, 0, 4'b0101, 1, 8'hA3);  // flush beats read

    foreach (vecs[i]) begin
      drive0(vecs[i].flush, vecs[i].write, vecs[i].wdata, vecs[i].read);
      tick();
      check($sformatf("vec%0d level", i), 32'(bus0.fill_level), 32'(vecs[i].lvl));
      check($sformatf("vec%0d flags", i), 32'(flags0()), 32'(vecs[i].flags));
      if (vecs[i].chk) check($sformatf("vec%0d rdata", i), 32'(bus0.read_data), 32'(vecs[i].rdata));
    end

    // Alternating write/read, wrapping the pointers several times.
    for (int k = 0; k < 10; k++) begin
      drive0(0, 1, 8'(k), 0);
      tick();
      check($sformatf("wrap%0d level after write", k), 32'(bus0.fill_level), 1);
      drive0(0, 0, 8'h00, 1);
      tick();
      check($sformatf("wrap%0d rdata", k), 32'(bus0.read_data), 32'(k));
      check($sformatf("wrap%0d level after read", k), 32'(bus0.fill_level), 0);
    end
    drive0(0, 0, 8'h00, 0);

    // First-word-fall-through instance.
    drive1(1, 8'hA5, 0);
    tick();
    check("fwft head after write", 32'(bus1.read_data), 32'hA5);
    check("fwft empty after write", 32'(bus1.empty), 0);
    drive1(1, 8'hB6, 0);
    tick();
    check("fwft head held", 32'(bus1.read_data), 32'hA5);
    check("fwft level 2", 32'(bus1.fill_level), 2);
    drive1(0, 8'h00, 1);
    tick();
    check("fwft next head", 32'(bus1.read_data), 32'hB6);
    tick();
    check("fwft empty after reads", 32'(bus1.empty), 1);
    check("fwft level 0", 32'(bus1.fill_level), 0);
    drive1(0, 8'h00, 0);

`ifdef FIFO_ERR_FLAGS_EN
    bus0.err_clr = 1'b1;
    tick();
    bus0.err_clr = 1'b0;
    check("err cleared ovf", 32'(bus0.overflow), 0);
    check("err cleared udf", 32'(bus0.underflow), 0);
    for (int k = 0; k < 3; k++) begin
      drive0(0, 1, 8'(8'h20 + k), 0);
      tick();
    end
    check("ovf before overflow", 32'(bus0.overflow), 0);
    drive0(0, 1, 8'hEE, 0);
    tick();
    check("ovf set", 32'(bus0.overflow), 1);
    drive0(0, 0, 8'h00, 0);
    tick();
    check("ovf sticky", 32'(bus0.overflow), 1);
    drive0(0, 0, 8'h00, 1);
    repeat (3) tick();
    check("udf before underflow", 32'(bus0.underflow), 0);
    tick();
    check("udf set", 32'(bus0.underflow), 1);
    drive0(1, 0, 8'h00, 0);
    tick();
    check("flush keeps ovf", 32'(bus0.overflow), 1);
    check("flush keeps udf", 32'(bus0.underflow), 1);
    drive0(0, 0, 8'h00, 1);
    bus0.err_clr = 1'b1;
    tick();
    check("clr+udf event ovf", 32'(bus0.overflow), 0);
    check("clr+udf event udf", 32'(bus0.underflow), 1);
    drive0(0, 0, 8'h00, 0);
    tick();
    bus0.err_clr = 1'b0;
    check("clr udf", 32'(bus0.underflow), 0);
`endif

    // Reset in the middle of traffic.
    for (int k = 0; k < 4; k++) begin
      drive0(0, 1, 8'(8'hD1 + k), 0);
      tick();
    end
    drive0(0, 0, 8'h00, 1);
    tick();
    drive0(0, 0, 8'h00, 0);
    check("pre-reset rdata", 32'(bus0.read_data), 32'hD1);
    check("pre-reset level", 32'(bus0.fill_level), 2);
`ifdef FIFO_ERR_FLAGS_EN
    check("pre-reset ovf", 32'(bus0.overflow), 1);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("mid reset level", 32'(bus0.fill_level), 0);
    check("mid reset flags", 32'(flags0()), 32'b0101);
    check("mid reset rdata", 32'(bus0.read_data), 0);
`ifdef FIFO_ERR_FLAGS_EN
    check("mid reset ovf", 32'(bus0.overflow), 0);
    check("mid reset udf", 32'(bus0.underflow), 0);
`endif
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    drive0(0, 1, 8'hE5, 0);
    tick();
    check("post-reset level", 32'(bus0.fill_level), 1);
    drive0(0, 0, 8'h00, 1);
    tick();
    check("post-reset rdata", 32'(bus0.read_data), 32'hE5);
    check("post-reset empty", 32'(bus0.empty), 1);
    drive0(0, 0, 8'h00, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_flex.md
FIFO_FLEX -- requirements
Module: fifo_flex

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the entry width in bits (>=1).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, meaning the entry count (>=1); it need not be a power of two.
REQ-003 The block SHALL have parameter FWFT, default 0, meaning read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 The block SHALL have parameter AF_THRESH, default FIFO_DEPTH-1, meaning the almost-full level (1..FIFO_DEPTH).
REQ-005 The block SHALL have parameter AE_THRESH, default 1, meaning the almost-empty level (0..FIFO_DEPTH-1).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port flush, input, 1 bit: synchronous empty request.
REQ-009 The block SHALL have port write, input, 1 bit: write request.
REQ-010 The block SHALL have port write_data, input, DATA_WIDTH bits: data to write.
REQ-011 The block SHALL have port read, input, 1 bit: read request.
REQ-012 The block SHALL have port read_data, output, DATA_WIDTH bits: data read out.
REQ-013 The block SHALL have port fill_level, output, $clog2(FIFO_DEPTH+1) bits: entries held.
REQ-014 The block SHALL have ports full, empty, almost_full and almost_empty, each output, 1 bit: status flags.
REQ-015 The block SHALL have ports err_clr (input), overflow (output) and underflow (output), each 1 bit, present only under FIFO_ERR_FLAGS_EN.

Function
REQ-016 The block SHALL accept a write when write=1 and (full=0 or a read is accepted in the same cycle).
REQ-017 The block SHALL accept a read when read=1 and empty=0; a read while empty SHALL be ignored, even with a simultaneous write.
REQ-018 The block SHALL apply an accepted write and an accepted read in the same cycle together, leaving fill_level unchanged.
REQ-019 The block SHALL wrap the read and write pointers from FIFO_DEPTH-1 to 0 for any FIFO_DEPTH, with no power-of-two assumption.
REQ-020 The block SHALL drive full, empty, almost_full and almost_empty from the registered count: full = (fill_level==FIFO_DEPTH), empty = (fill_level==0), almost_full = (fill_level>=AF_THRESH), almost_empty = (fill_level<=AE_THRESH).
REQ-021 The block SHALL update fill_level and the flags in the cycle after the accepting edge.
REQ-022 With FWFT=0, read_data SHALL update on the edge that accepts a read (visible next cycle) and hold its value otherwise.
REQ-023 With FWFT=1, read_data SHALL show the head entry whenever empty=0; an accepted read SHALL advance to the next entry on the following cycle.
REQ-024 With FWFT=1, read_data SHALL be don't-care while empty=1.
REQ-025 Flush SHALL take priority over read and write in the same cycle: pointers and count go to 0, and both requests are dropped.
REQ-026 Flush SHALL leave the FWFT=0 read_data register unchanged.
REQ-027 Flush SHALL NOT clear the overflow or underflow flags.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately clear the pointers and count, giving fill_level=0, empty=1, full=0, almost_empty=1 and almost_full=0.
REQ-029 Asserting rst_n=0 SHALL immediately clear read_data to 0, and overflow and underflow to 0.
REQ-030 Storage contents SHALL NOT be reset.
REQ-031 Reset in the middle of operation SHALL discard all entries; the first write after release SHALL go to slot 0.

Configuration
REQ-032 When macro FIFO_ERR_FLAGS_EN is defined, the block SHALL include ports err_clr, overflow and underflow.
REQ-033 Under FIFO_ERR_FLAGS_EN, overflow SHALL be sticky and set one cycle after a cycle with write=1 and full=1 and no accepted read.
REQ-034 Under FIFO_ERR_FLAGS_EN, underflow SHALL be sticky and set one cycle after a cycle with read=1 and empty=1.
REQ-035 Under FIFO_ERR_FLAGS_EN, err_clr=1 SHALL clear both flags on the next edge; a new error event in the same cycle SHALL win.
REQ-036 Without FIFO_ERR_FLAGS_EN, those ports and their logic SHALL be absent, and dropped writes and reads SHALL be silent.

Verification (DATA_WIDTH=8, FIFO_DEPTH=3, AF_THRESH=2, AE_THRESH=1)
REQ-037 Scenario 1: write 0x11, 0x22, 0x33 on consecutive cycles -> fill_level goes 1, 2, 3, almost_full rises at 2, full rises at 3; then read 3 times -> 0x11, 0x22, 0x33 in order, empty rises.
REQ-038 Scenario 2: wrap-around, 10 cycles of alternating single write and read of 0x00..0x09 -> data returned in order, fill_level never exceeds 1.
REQ-039 Scenario 3: full FIFO with write=1 and read=1 of 0x44 -> oldest entry read, fill_level stays 3, 0x44 read out last.
REQ-040 Scenario 4: FWFT=1, write 0xA5 into an empty FIFO -> read_data=0xA5 one cycle later with no read; a read then gives empty=1.
REQ-041 Scenario 5: flush with write=1 and fill_level=2 -> fill_level=0 and empty=1 next cycle, write dropped.
REQ-042 Scenario 6 (FIFO_ERR_FLAGS_EN): write when full gives overflow=1 held; read when empty gives underflow=1; err_clr clears both; rst_n=0 mid-stream clears everything immediately.
